// File: rtl/lfsr_rnd_pkg.sv
// Shared constants and types for the LFSR random-word arbiter.
// Optional statistics outputs are enabled with LFSR_RND_STATS_EN (see lfsr_rnd_arbiter).
package lfsr_rnd_pkg;
  localparam int WIDTH_DEFAULT = 52;
  localparam logic [WIDTH_DEFAULT-1:0] SEED_DEFAULT = 52'hF;

  // Feedback taps for x^52 polynomial, Fibonacci form
  localparam int TAP_A = 51;
  localparam int TAP_B = 3;
  localparam int TAP_C = 2;
  localparam int TAP_D = 0;

  typedef enum logic {FILL, READY} rnd_state_t;
endpackage

// File: rtl/lfsr_rnd_core.sv
// Fibonacci LFSR register with shift enable and seed load.
// An all-zero load value is replaced by SEED so the register can never lock up.
module lfsr_core import lfsr_rnd_pkg::*; #(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] SEED  = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             fb;

  assign fb = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (load_val == '0) ? SEED : load_val;
    end else if (shift_en) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;
endmodule

// File: rtl/lfsr_rnd_arbiter.sv
// Round-robin distribution of fresh LFSR words to N_REQ requesters.
// Define LFSR_RND_STATS_EN to add the words_served / lockup_err outputs.
//
// state | meaning
// FILL  | shifting SHIFTS_PER_WORD times to build a fresh word
// READY | word complete, LFSR held, waiting for a request
module lfsr_rnd_arbiter import lfsr_rnd_pkg::*; #(
  parameter int               N_REQ           = 4,
  parameter int               WIDTH           = WIDTH_DEFAULT,
  parameter int               SHIFTS_PER_WORD = 52,
  parameter logic [WIDTH-1:0] SEED            = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [WIDTH-1:0] rnd_data,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             busy
`ifdef LFSR_RND_STATS_EN
  ,
  output logic [15:0]      words_served,
  output logic             lockup_err
`endif
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(SHIFTS_PER_WORD + 1);

  rnd_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    ptr_q, ptr_d, gnt_idx;
  logic [N_REQ-1:0] ack_q;
  logic [WIDTH-1:0] data_q, lfsr;
  logic [PW:0]      cand;
  logic             gnt_vld, shift_en;

  assign shift_en = (state_q == FILL) && !seed_load;

  lfsr_core #(.WIDTH(WIDTH), .SEED(SEED)) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  // First requester at or after the pointer, wrapping modulo N_REQ
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!gnt_vld && req[cand[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  assign ptr_d = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      ack_q <= '0;
      if (seed_load) begin
        // Reseed wins over a grant in the same cycle; pointer and data keep their values
        state_q <= FILL;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          FILL: begin
            if (cnt_q == CW'(SHIFTS_PER_WORD - 1)) begin
              cnt_q   <= '0;
              state_q <= READY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          READY: begin
            if (gnt_vld) begin
              ack_q   <= N_REQ'(1) << gnt_idx;
              data_q  <= lfsr;
              ptr_q   <= ptr_d;
              state_q <= FILL;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign ack      = ack_q;
  assign rnd_data = data_q;
  assign busy     = (state_q == FILL);

`ifdef LFSR_RND_STATS_EN
  logic [15:0] served_q;
  logic        lock_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      if (|ack_q && served_q != 16'hFFFF) served_q <= served_q + 16'd1;
      if (lfsr == '0) lock_q <= 1'b1;
    end
  end

  assign words_served = served_q;
  assign lockup_err   = lock_q;
`endif
endmodule

// File: tb/tb_lfsr_rnd_arbiter.sv
// Scoreboard bench for lfsr_rnd_arbiter: word-level reference model predicts
// which requester gets which word on which cycle; a monitor checks every ack.
module tb_lfsr_rnd_arbiter;
  localparam int N   = 4;
  localparam int W   = 52;
  localparam int SPW = 52;
  localparam logic [W-1:0] SEED       = 52'hF;
  localparam logic [W-1:0] FIRST_WORD = 52'hF_FFFF_FFFF_FFF4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         seed_load = 1'b0;
  logic [N-1:0] req = '0;
  logic [W-1:0] seed_in = '0;
  logic [N-1:0] ack;
  logic [W-1:0] rnd_data;
  logic         busy;
`ifdef LFSR_RND_STATS_EN
  logic [15:0]  words_served;
  logic         lockup_err;
`endif

  lfsr_rnd_arbiter #(.N_REQ(N), .WIDTH(W), .SHIFTS_PER_WORD(SPW), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ack       (ack),
    .rnd_data  (rnd_data),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy)
`ifdef LFSR_RND_STATS_EN
    ,
    .words_served (words_served),
    .lockup_err   (lockup_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current word, cycle the word becomes ready, rr pointer
  logic [W-1:0] m_word;
  int m_ready, m_ptr, m_last_g, m_served;
  int want[N];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] v, input int n);
    logic [W-1:0] x;
    x = v;
    for (int k = 0; k < n; k++) x = {x[W-2:0], x[51] ^ x[3] ^ x[2] ^ x[0]};
    return x;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) req[i] = (want[i] > 0);
  endtask

  // One cycle: requesters drop demand on their own ack, seed_load is a one-edge pulse
  task automatic tick();
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < N; i++) if (ack[i] && want[i] > 0) want[i]--;
    drive_req();
  endtask

  // Predict every ack for the current demand; requests are visible from the next edge
  task automatic plan();
    int w[N];
    int left, g, k;
    left = 0;
    for (int i = 0; i < N; i++) begin
      w[i] = want[i];
      left += w[i];
    end
    g = (m_ready + 1 > cyc + 1) ? m_ready + 1 : cyc + 1;
    while (left > 0) begin
      exp_t e;
      k = m_ptr;
      while (w[k] == 0) k = (k + 1) % N;
      e.idx = k;
      e.data = m_word;
      e.cyc = g;
      sb.push_back(e);
      w[k]--;
      left--;
      m_ptr = (k + 1) % N;
      m_word = advance(m_word, SPW);
      m_ready = g + SPW;
      m_last_g = g;
      m_served++;
      g = g + SPW + 1;
    end
  endtask

  task automatic seed_pulse(input logic [W-1:0] v);
    seed_in = v;
    seed_load = 1'b1;
    m_word = advance((v == '0) ? SEED : v, SPW);
    m_ready = cyc + 1 + SPW;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_ack", ack, 0);
    check("rst_data", rnd_data, 0);
    check("rst_busy", busy, 1);
    tick();
    tick();
    reset = 1'b0;
    m_word = advance(SEED, SPW);
    m_ptr = 0;
    m_ready = cyc + SPW;
    m_served = 0;
  endtask

  task automatic wait_drain(input string name);
    int lim;
    lim = 0;
    while (sb.size() > 0 && lim < 1000) begin
      tick();
      lim++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d acks outstanding, expected 0", name, sb.size());
      sb.delete();
      for (int i = 0; i < N; i++) want[i] = 0;
      drive_req();
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard
  initial begin
    exp_t e;
    int got;
    forever begin
      @(negedge clk);
      if (!reset && ack !== '0) begin
        got = -1;
        for (int i = 0; i < N; i++) if (ack[i]) got = i;
        check("ack_onehot", $countones(ack), 1);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ack=%b expected none (cycle %0d)", ack, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_idx", got, e.idx);
          check("ack_data", rnd_data, e.data);
          check("ack_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int c0;
    logic [N-1:0] mask;
    for (int i = 0; i < N; i++) want[i] = 0;
    m_served = 0;
    m_last_g = 0;
    tick();

    // First word after reset, busy timing
    apply_reset();
    c0 = cyc;
    want[0] = 1;
    drive_req();
    plan();
    while (cyc < c0 + SPW - 1) tick();
    check("busy_fill", busy, 1);
    tick();
    check("busy_ready", busy, 0);
    wait_drain("first_word");
    check("first_word", rnd_data, FIRST_WORD);

    // All four requesting from pointer 0: order 0,1,2,3,0 at 53-cycle spacing
    apply_reset();
    want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
    drive_req();
    plan();
    wait_drain("rr_all");

    // Randomized demand, idle gaps and reseeds
    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(0, 70)) tick();
      if ($urandom_range(0, 2) == 0) seed_pulse(($urandom_range(0, 3) == 0) ? '0 : rand_word());
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) want[i] = mask[i] ? int'($urandom_range(1, 2)) : 0;
      drive_req();
      plan();
      wait_drain("random");
    end

    // Zero seed behaves like reset seed
    repeat (10) tick();
    seed_pulse('0);
    want[2] = 1;
    drive_req();
    plan();
    wait_drain("zero_seed");
    check("zero_seed_word", rnd_data, FIRST_WORD);

    // Reseed in the same cycle as a READY grant cancels it
    while (cyc < m_ready + 2) tick();
    seed_pulse(rand_word() | 52'h1);
    want[1] = 1; want[2] = 1;
    drive_req();
    plan();
    tick();
    check("collision_no_ack", ack, 0);
    wait_drain("collision");

    // Reset in the middle of FILL
    want[0] = 1;
    drive_req();
    plan();
    wait_drain("pre_reset");
    while (cyc < m_last_g + 20) tick();
    want[3] = 1;
    drive_req();
    apply_reset();
    plan();
    wait_drain("mid_fill_reset");
    check("mid_fill_reset_word", rnd_data, FIRST_WORD);

    tick();
    tick();
    check("queue_empty", sb.size(), 0);
`ifdef LFSR_RND_STATS_EN
    check("words_served", words_served, m_served);
    check("lockup_err", lockup_err, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
